// File: rtl/pipe_reg_pkg.sv
// rtl/pipe_reg_pkg.sv - shared constants and helpers for the elastic pipeline register
package pipe_reg_pkg;

  localparam int PIPE_REG_DEF_WIDTH = 8;
  localparam int PIPE_REG_DEF_DEPTH = 2;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// rtl/pipe_reg_stage.sv - one data+valid stage of the elastic pipeline register
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = PIPE_REG_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Valid follows upstream on advance; data loads only with a real item, so bubbles never toggle it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= RESET_VAL;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - elastic pipeline register with bubble collapse and flush; PIPE_REG_OCCUPANCY_EN adds occupancy
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = PIPE_REG_DEF_WIDTH,
  parameter int               DEPTH     = PIPE_REG_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;

  // Advance chain from the output side: a stage moves if downstream moves or it is empty.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_ready | ~valid[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = adv[i+1] | ~valid[i];
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (i == 0) begin : g_head
      assign d_in = in_data;
      assign v_in = in_valid;
    end else begin : g_body
      assign d_in = data[i-1];
      assign v_in = valid[i-1];
    end

    pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .adv      (adv[i]),
      .in_data  (d_in),
      .in_valid (v_in),
      .data     (data[i]),
      .valid    (valid[i])
    );
  end

`ifdef PIPE_REG_OCCUPANCY_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Item count after each edge; flush wins over any same-cycle transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  a_occ_matches_valid : assert property (
    @(posedge clk) disable iff (reset) occupancy == OCC_W'($countones(valid))
  );
`else
  // Occupancy tracking not built; the datapath is identical.
`endif

endmodule
